// File: rtl/hazard_pkg.sv
// Purpose : shared types and helpers for the forwarding/hazard unit.
// Contents: forwarding-select enum, per-stage shadow record, bubble constant,
//           producer-match and select helper functions.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

  // A stage produces register r; x0 never counts as a producer.
  function automatic logic match(stage_info_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
  endfunction

  // Operand select for one source; the EX stage is the newest producer and wins.
  function automatic fwd_sel_t pick_sel(logic issue, logic use_r,
                                        logic [REG_ADDR_W-1:0] r,
                                        stage_info_t ex_s, stage_info_t mem_s);
    if (!issue || !use_r) return FWD_RF;
    if (match(ex_s, r))   return FWD_MEM;
    if (match(mem_s, r))  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Purpose: ID-side bundle between the pipeline and the forwarding/hazard unit.
// Ports  : master = pipeline (drives ID fields and ex_flush),
//          slave  = hazard unit (drives stall, selects, ex_valid, counters,
//          and the WB shadow record for tracing).
interface fwd_hazard_unit_if import hazard_pkg::*; #(
  parameter int unsigned CNT_W = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_flush;
  logic                  stall;
  fwd_sel_t              fwd_a;
  fwd_sel_t              fwd_b;
  logic                  ex_valid;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  stage_info_t           wb_stage;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, ex_flush,
    input  stall, fwd_a, fwd_b, ex_valid, stall_cnt, flush_cnt, wb_stage
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, ex_flush,
    output stall, fwd_a, fwd_b, ex_valid, stall_cnt, flush_cnt, wb_stage
  );
endinterface

// File: rtl/hazard_shadow_reg.sv
// Purpose: one shadow pipeline stage record.
// Ports  : clk, reset (async, active-high), load_i (capture d_i),
//          bubble_i (insert BUBBLE, overrides load), d_i, q_o (registered).
module hazard_shadow_reg import hazard_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        bubble_i,
  input  stage_info_t d_i,
  output stage_info_t q_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_o <= BUBBLE;
    end else if (bubble_i) begin
      q_o <= BUBBLE;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Purpose: operand forwarding selects, load-use stall and flush handling for
//          the 5-stage pipeline, with saturating stall/flush counters.
// Ports  : clk, reset (async, active-high), bus (slave side of
//          fwd_hazard_unit_if). stall is combinational; every other output
//          is registered.
module fwd_hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  fwd_hazard_unit_if.slave  bus
);
  import hazard_pkg::*;

  stage_info_t ex_q, mem_q, wb_q, id_info;
  logic        stall_c;
  logic        id_issue;
  fwd_sel_t    fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic        ex_valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // Load in EX feeding an ID source; only ex_q is involved, so reset drops it at once.
  assign stall_c = bus.id_valid && !bus.ex_flush && ex_q.memread &&
                   ((bus.id_use_rs1 && match(ex_q, bus.id_rs1)) ||
                    (bus.id_use_rs2 && match(ex_q, bus.id_rs2)));

  assign id_issue = bus.id_valid && !stall_c && !bus.ex_flush;

  assign id_info = '{valid: 1'b1, rd: bus.id_rd,
                     regwrite: bus.id_regwrite, memread: bus.id_memread};

  // Shadow pipeline: EX takes ID or a bubble, MEM and WB just shift.
  hazard_shadow_reg u_ex (
    .clk(clk), .reset(reset), .load_i(1'b1), .bubble_i(!id_issue),
    .d_i(id_info), .q_o(ex_q)
  );
  hazard_shadow_reg u_mem (
    .clk(clk), .reset(reset), .load_i(1'b1), .bubble_i(1'b0),
    .d_i(ex_q), .q_o(mem_q)
  );
  hazard_shadow_reg u_wb (
    .clk(clk), .reset(reset), .load_i(1'b1), .bubble_i(1'b0),
    .d_i(mem_q), .q_o(wb_q)
  );

  // Next selects and saturating counters.
  always_comb begin
    fwd_a_d     = pick_sel(id_issue, bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
    fwd_b_d     = pick_sel(id_issue, bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.ex_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      ex_valid_q  <= id_issue;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.wb_stage  = wb_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose: scoreboard bench for fwd_hazard_unit. The driver keeps a list of
//          in-flight instructions (newest first) and derives stall/selects
//          from producer distance; a negedge monitor pops and compares.
module tb_fwd_hazard_unit;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.CNT_W(CNT_W)) bus();
  fwd_hazard_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {bit v; int rd; bit rw; bit mr;} ins_t;
  typedef struct {bit st; int fa; int fb; bit exv; int sc; int fc; int wb;} exp_t;

  ins_t inflight[$];   // [0]=EX, [1]=MEM, [2]=WB
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_fa, cur_fb, cur_sc, cur_fc;
  bit   cur_exv;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit writes(ins_t p, int r);
    return p.v && p.rw && (p.rd != 0) && (p.rd == r);
  endfunction

  function automatic int pack_ins(ins_t p);
    return (int'(p.v) << 7) | (p.rd << 2) | (int'(p.rw) << 1) | int'(p.mr);
  endfunction

  // Select code equals producer distance (1 = just ahead, 2 = two ahead).
  function automatic int src_sel(bit issue, bit use_r, int r);
    if (!issue || !use_r) return 0;
    for (int age = 0; age < 2; age++)
      if (writes(inflight[age], r)) return age + 1;
    return 0;
  endfunction

  function automatic bit load_use(bit v, bit fl, int rs1, bit u1, int rs2, bit u2);
    ins_t p = inflight[0];
    return v && !fl && p.mr && ((u1 && writes(p, rs1)) || (u2 && writes(p, rs2)));
  endfunction

  task automatic reset_model();
    ins_t b = '{1'b0, 0, 1'b0, 1'b0};
    inflight.delete();
    repeat (3) inflight.push_back(b);
    cur_fa = 0; cur_fb = 0; cur_exv = 1'b0; cur_sc = 0; cur_fc = 0;
  endtask

  // One ID cycle: drive, predict, push expectation, advance model across the edge.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit rw, input bit mr, input bit fl, output bit st);
    exp_t e;
    ins_t n;
    bit   issue;
    int   nfa, nfb;
    bus.id_valid = v;   bus.id_rs1 = 5'(rs1); bus.id_use_rs1 = u1;
    bus.id_rs2 = 5'(rs2); bus.id_use_rs2 = u2; bus.id_rd = 5'(rd);
    bus.id_regwrite = rw; bus.id_memread = mr; bus.ex_flush = fl;
    st = load_use(v, fl, rs1, u1, rs2, u2);
    e = '{st, cur_fa, cur_fb, cur_exv, cur_sc, cur_fc, pack_ins(inflight[2])};
    exp_q.push_back(e);
    issue = v && !st && !fl;
    nfa = src_sel(issue, u1, rs1);
    nfb = src_sel(issue, u2, rs2);
    if (st && cur_sc < CMAX) cur_sc++;
    if (fl && cur_fc < CMAX) cur_fc++;
    n = issue ? '{1'b1, rd, rw, mr} : '{1'b0, 0, 1'b0, 1'b0};
    inflight.push_front(n);
    void'(inflight.pop_back());
    @(posedge clk);
    cur_fa = nfa; cur_fb = nfb; cur_exv = issue;
    #1;
  endtask

  // Present an instruction until it leaves ID (a load-use holds it one extra cycle).
  task automatic instr(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit mr);
    bit s;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, rs1, u1, rs2, u2, rd, rw, mr, 1'b0, s);
      if (!s) break;
    end
  endtask

  task automatic idle(input int n);
    bit s;
    repeat (n) step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, s);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",     int'(bus.stall),     int'(e.st));
      chk("fwd_a",     int'(bus.fwd_a),     e.fa);
      chk("fwd_b",     int'(bus.fwd_b),     e.fb);
      chk("ex_valid",  int'(bus.ex_valid),  int'(e.exv));
      chk("stall_cnt", int'(bus.stall_cnt), e.sc);
      chk("flush_cnt", int'(bus.flush_cnt), e.fc);
      chk("wb_stage",  int'(bus.wb_stage),  e.wb);
    end
  end

  initial begin
    bit s, held, v, u1, u2, rw, mr, fl;
    int rs1, rs2, rd;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0; bus.id_rd = '0; bus.id_regwrite = 1'b0;
    bus.id_memread = 1'b0; bus.ex_flush = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_fwd_a", int'(bus.fwd_a), 0);
    chk("rst_fwd_b", int'(bus.fwd_b), 0);
    chk("rst_ex_valid", int'(bus.ex_valid), 0);
    chk("rst_stall_cnt", int'(bus.stall_cnt), 0);
    chk("rst_flush_cnt", int'(bus.flush_cnt), 0);
    reset = 1'b0;

    // back-to-back ALU pair: add x5; sub x6,x5,x7
    instr(1, 1, 2, 1, 5, 1, 0);
    instr(5, 1, 7, 1, 6, 1, 0);
    idle(2);
    // gap of one: add x5; nop; or x8,x5,x5
    instr(1, 1, 2, 1, 5, 1, 0);
    instr(0, 1, 0, 0, 0, 1, 0);
    instr(5, 1, 5, 1, 8, 1, 0);
    idle(2);
    // gap of two
    instr(1, 1, 2, 1, 5, 1, 0);
    instr(0, 1, 0, 0, 0, 1, 0);
    instr(0, 1, 0, 0, 0, 1, 0);
    instr(5, 1, 5, 1, 8, 1, 0);
    idle(3);
    // load-use: lw x9; add x10,x9,x1
    instr(2, 1, 0, 0, 9, 1, 1);
    instr(9, 1, 1, 1, 10, 1, 0);
    idle(3);
    // two producers of x5, newest wins
    instr(1, 1, 2, 1, 5, 1, 0);
    instr(3, 1, 4, 1, 5, 1, 0);
    instr(5, 1, 5, 1, 11, 1, 0);
    idle(2);
    // x0 is never a producer
    instr(1, 1, 2, 1, 0, 1, 0);
    instr(0, 1, 0, 1, 12, 1, 0);
    instr(2, 1, 0, 0, 0, 1, 1);
    instr(0, 1, 0, 1, 13, 1, 0);
    idle(3);
    // load-use coincident with a flush: flush wins
    instr(2, 1, 0, 0, 9, 1, 1);
    step(1'b1, 9, 1'b1, 1, 1'b1, 10, 1'b1, 1'b0, 1'b1, s);
    idle(3);
    // stall counter saturation
    repeat (20) begin
      instr(2, 1, 0, 0, 9, 1, 1);
      instr(9, 1, 1, 1, 10, 1, 0);
    end
    idle(2);

    // randomized traffic on a small register set to provoke hazards
    held = 1'b0;
    v = 0; u1 = 0; u2 = 0; rw = 0; mr = 0; rs1 = 0; rs2 = 0; rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        v   = ($urandom_range(0, 9) != 0);
        rs1 = $urandom_range(0, 3); u1 = $urandom_range(0, 3) != 0;
        rs2 = $urandom_range(0, 3); u2 = $urandom_range(0, 1) != 0;
        rd  = $urandom_range(0, 3); rw = $urandom_range(0, 3) != 0;
        mr  = rw && ($urandom_range(0, 2) == 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      step(v, rs1, u1, rs2, u2, rd, rw, mr, fl, s);
      held = s;
    end
    idle(3);

    // reset asserted mid-stall clears outputs without a clock edge
    instr(2, 1, 0, 0, 9, 1, 1);
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
    bus.id_rs2 = 5'd1; bus.id_use_rs2 = 1'b1; bus.id_rd = 5'd10;
    bus.id_regwrite = 1'b1; bus.id_memread = 1'b0; bus.ex_flush = 1'b0;
    #1;
    chk("stall_before_reset", int'(bus.stall), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_stall", int'(bus.stall), 0);
    chk("async_rst_fwd_a", int'(bus.fwd_a), 0);
    chk("async_rst_fwd_b", int'(bus.fwd_b), 0);
    chk("async_rst_ex_valid", int'(bus.ex_valid), 0);
    chk("async_rst_stall_cnt", int'(bus.stall_cnt), 0);
    chk("async_rst_flush_cnt", int'(bus.flush_cnt), 0);
    chk("async_rst_wb", int'(bus.wb_stage), 0);
    bus.id_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    reset = 1'b0;

    // recovery after reset
    instr(2, 1, 0, 0, 9, 1, 1);
    instr(9, 1, 1, 1, 10, 1, 0);
    idle(3);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
